// File: rtl/tile_shape_server_pkg.sv
// Shared tile geometry types for the tile-shape read path.
// Also holds the row-scan helpers used by the scanner.
package tetris;

    localparam int TILE_ADDR_W = 5;
    localparam int TILE_GRID   = 4;

    typedef enum logic [2:0] {
        eNon = 3'd0, eI, eO, eT, eS, eZ, eJ, eL
    } tile_type_e;

    typedef struct packed {
        logic [1:0] x_m;
        logic [1:0] y_m;
    } point_t;

    typedef struct packed {
        logic [15:0] bitmap_m;
        logic [1:0]  min_x_m;
        logic [1:0]  max_x_m;
        logic [1:0]  min_y_m;
        logic [1:0]  max_y_m;
        logic        empty_m;
    } shape_info_t;

    typedef enum logic [1:0] {IDLE, LOOKUP, SCAN, DONE} srv_state_e;

    function automatic logic [1:0] row_low_bit(input logic [3:0] row);
        row_low_bit = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (row[c]) row_low_bit = 2'(c);
        end
    endfunction

    function automatic logic [1:0] row_high_bit(input logic [3:0] row);
        row_high_bit = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (row[c]) row_high_bit = 2'(c);
        end
    endfunction

endpackage

// File: rtl/tile_shape_server_if.sv
// Request/response bundle between a geometry client and tile_shape_server.
interface tile_shape_server_if;
    import tetris::*;

    logic [TILE_ADDR_W-1:0] rd_addr_i;
    logic                   rd_v_i;
    logic                   rd_ready_o;
    shape_info_t            shape_info_o;
    logic                   shape_v_o;

    modport master (output rd_addr_i, rd_v_i, input rd_ready_o, shape_info_o, shape_v_o);
    modport slave  (input rd_addr_i, rd_v_i, output rd_ready_o, shape_info_o, shape_v_o);
endinterface

// File: rtl/tile_bitmap_rom.sv
// 4x4 occupancy bitmaps for every {tile_type, angle}; bit 4*y+x, y=0 is the top row.
// Each angle step is a clockwise turn: I turns in the 4x4 grid, O is fixed, the rest turn in a 3x3 box.
module tile_bitmap_rom
    import tetris::*;
(
    input  logic [TILE_ADDR_W-1:0] i_addr,
    output logic [15:0]            o_bitmap
);

    always_comb begin
        o_bitmap = 16'h0000;
        case (i_addr)
            {eI, 2'd0}: o_bitmap = 16'h00F0;
            {eI, 2'd1}: o_bitmap = 16'h4444;
            {eI, 2'd2}: o_bitmap = 16'h0F00;
            {eI, 2'd3}: o_bitmap = 16'h2222;
            {eO, 2'd0}: o_bitmap = 16'h0066;
            {eO, 2'd1}: o_bitmap = 16'h0066;
            {eO, 2'd2}: o_bitmap = 16'h0066;
            {eO, 2'd3}: o_bitmap = 16'h0066;
            {eT, 2'd0}: o_bitmap = 16'h0072;
            {eT, 2'd1}: o_bitmap = 16'h0262;
            {eT, 2'd2}: o_bitmap = 16'h0270;
            {eT, 2'd3}: o_bitmap = 16'h0232;
            {eS, 2'd0}: o_bitmap = 16'h0036;
            {eS, 2'd1}: o_bitmap = 16'h0462;
            {eS, 2'd2}: o_bitmap = 16'h0360;
            {eS, 2'd3}: o_bitmap = 16'h0231;
            {eZ, 2'd0}: o_bitmap = 16'h0063;
            {eZ, 2'd1}: o_bitmap = 16'h0264;
            {eZ, 2'd2}: o_bitmap = 16'h0630;
            {eZ, 2'd3}: o_bitmap = 16'h0132;
            {eJ, 2'd0}: o_bitmap = 16'h0071;
            {eJ, 2'd1}: o_bitmap = 16'h0226;
            {eJ, 2'd2}: o_bitmap = 16'h0470;
            {eJ, 2'd3}: o_bitmap = 16'h0322;
            {eL, 2'd0}: o_bitmap = 16'h0074;
            {eL, 2'd1}: o_bitmap = 16'h0622;
            {eL, 2'd2}: o_bitmap = 16'h0170;
            {eL, 2'd3}: o_bitmap = 16'h0223;
            default:    o_bitmap = 16'h0000;
        endcase
    end

endmodule

// File: rtl/tile_shape_server.sv
// Tile-shape responder: bitmap lookup followed by a one-row-per-cycle extent scan.
// Optional TILE_SHAPE_CACHE_EN answers a repeat of the last completed address in one cycle.
module tile_shape_server
    import tetris::*;
#(
    parameter int SCAN_ROWS = 4
)(
    input  logic                clk_i,
    input  logic                reset_i,
    tile_shape_server_if.slave  bus
);

    generate
        if (SCAN_ROWS != TILE_GRID) begin : g_bad_scan_rows
            $error("SCAN_ROWS must equal TILE_GRID");
        end
    endgenerate

    srv_state_e             r_state;
    logic [TILE_ADDR_W-1:0] r_last_addr;
    logic [15:0]            r_bitmap;
    logic [1:0]             r_row_cnt;
    logic                   r_scan_done;
    logic [1:0]             r_min_x, r_max_x, r_min_y, r_max_y;
    logic                   r_any;
    shape_info_t            r_info;
    logic                   r_shape_v;

    logic [15:0]            w_rom_bitmap;
    logic [3:0]             w_row;
    logic                   w_ready;
    logic                   w_accept;
    logic [1:0]             w_row_lo, w_row_hi;

    tile_bitmap_rom u_rom (
        .i_addr   (r_last_addr),
        .o_bitmap (w_rom_bitmap)
    );

    assign w_ready  = ((r_state == IDLE) || (r_state == DONE)) && !reset_i;
    assign w_accept = bus.rd_v_i && w_ready;
    assign w_row    = r_bitmap[{r_row_cnt, 2'b00} +: 4];
    assign w_row_lo = row_low_bit(w_row);
    assign w_row_hi = row_high_bit(w_row);

`ifdef TILE_SHAPE_CACHE_EN
    logic r_cache_v;
    logic w_cache_hit;
    assign w_cache_hit = r_cache_v && (bus.rd_addr_i == r_last_addr);
`endif

    assign bus.rd_ready_o   = w_ready;
    assign bus.shape_info_o = r_info;
    assign bus.shape_v_o    = r_shape_v;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_info      <= '0;
            r_shape_v   <= 1'b0;
            r_row_cnt   <= 2'd0;
            r_scan_done <= 1'b0;
`ifdef TILE_SHAPE_CACHE_EN
            r_cache_v   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_last_addr <= bus.rd_addr_i;
`ifdef TILE_SHAPE_CACHE_EN
                        if (w_cache_hit) begin
                            r_state   <= DONE;
                            r_shape_v <= 1'b1;
                        end else begin
                            r_state   <= LOOKUP;
                            r_shape_v <= 1'b0;
                        end
`else
                        r_state   <= LOOKUP;
                        r_shape_v <= 1'b0;
`endif
                    end
                end
                LOOKUP: begin
                    r_bitmap    <= w_rom_bitmap;
                    r_min_x     <= 2'd3;
                    r_min_y     <= 2'd3;
                    r_max_x     <= 2'd0;
                    r_max_y     <= 2'd0;
                    r_any       <= 1'b0;
                    r_row_cnt   <= 2'd0;
                    r_scan_done <= 1'b0;
                    r_state     <= SCAN;
                end
                SCAN: begin
                    // Four row cycles fill the accumulators; the cycle after the last row commits them.
                    if (!r_scan_done) begin
                        if (w_row != 4'd0) begin
                            if (r_row_cnt < r_min_y) r_min_y <= r_row_cnt;
                            r_max_y <= r_row_cnt;
                            if (w_row_lo < r_min_x) r_min_x <= w_row_lo;
                            if (w_row_hi > r_max_x) r_max_x <= w_row_hi;
                            r_any <= 1'b1;
                        end
                        r_row_cnt <= r_row_cnt + 2'd1;
                        if (r_row_cnt == 2'd3) r_scan_done <= 1'b1;
                    end else begin
                        r_info.bitmap_m <= r_bitmap;
                        r_info.min_x_m  <= r_any ? r_min_x : 2'd0;
                        r_info.max_x_m  <= r_any ? r_max_x : 2'd0;
                        r_info.min_y_m  <= r_any ? r_min_y : 2'd0;
                        r_info.max_y_m  <= r_any ? r_max_y : 2'd0;
                        r_info.empty_m  <= !r_any;
                        r_shape_v       <= 1'b1;
                        r_state         <= DONE;
`ifdef TILE_SHAPE_CACHE_EN
                        r_cache_v       <= 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_shape_server.sv
// Self-checking bench for tile_shape_server; tile geometry is rebuilt from piece cell lists.
module tb_tile_shape_server;
    import tetris::*;

    logic clk_i = 1'b0;
    logic reset_i;
    int   total = 0;
    int   bad   = 0;

    tile_shape_server_if bus();

    tile_shape_server #(.SCAN_ROWS(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Reference: place the piece's cells, rotate them clockwise, then take min/max over cells.
    function automatic shape_info_t model(input logic [4:0] a);
        int xs[4];
        int ys[4];
        int box;
        int t;
        int ang;
        int mnx, mxx, mny, mxy;
        shape_info_t s;
        t   = int'(a[4:2]);
        ang = int'(a[1:0]);
        s   = '0;
        box = 3;
        case (t)
            1: begin xs = '{0,1,2,3}; ys = '{1,1,1,1}; box = 4; end
            2: begin xs = '{1,2,1,2}; ys = '{0,0,1,1}; box = 0; end
            3: begin xs = '{1,0,1,2}; ys = '{0,1,1,1}; end
            4: begin xs = '{1,2,0,1}; ys = '{0,0,1,1}; end
            5: begin xs = '{0,1,1,2}; ys = '{0,0,1,1}; end
            6: begin xs = '{0,0,1,2}; ys = '{0,1,1,1}; end
            7: begin xs = '{2,0,1,2}; ys = '{0,1,1,1}; end
            default: begin
                s.empty_m = 1'b1;
                return s;
            end
        endcase
        if (box != 0) begin
            for (int r = 0; r < ang; r++) begin
                for (int i = 0; i < 4; i++) begin
                    int nx;
                    nx    = box - 1 - ys[i];
                    ys[i] = xs[i];
                    xs[i] = nx;
                end
            end
        end
        mnx = 3; mxx = 0; mny = 3; mxy = 0;
        for (int i = 0; i < 4; i++) begin
            s.bitmap_m[4*ys[i] + xs[i]] = 1'b1;
            if (xs[i] < mnx) mnx = xs[i];
            if (xs[i] > mxx) mxx = xs[i];
            if (ys[i] < mny) mny = ys[i];
            if (ys[i] > mxy) mxy = ys[i];
        end
        s.min_x_m = 2'(mnx);
        s.max_x_m = 2'(mxx);
        s.min_y_m = 2'(mny);
        s.max_y_m = 2'(mxy);
        return s;
    endfunction

    function automatic shape_info_t mk(input logic [15:0] bm, input int mnx, input int mxx,
                                       input int mny, input int mxy, input bit emp);
        shape_info_t s;
        s.bitmap_m = bm;
        s.min_x_m  = 2'(mnx);
        s.max_x_m  = 2'(mxx);
        s.min_y_m  = 2'(mny);
        s.max_y_m  = 2'(mxy);
        s.empty_m  = emp;
        return s;
    endfunction

    // Issue one request and count edges from acceptance until shape_v_o is seen high (20 = gave up).
    task automatic do_request(input logic [4:0] a, input bit noise, output int lat);
        @(negedge clk_i);
        bus.rd_addr_i = a;
        bus.rd_v_i    = 1'b1;
        @(posedge clk_i);
        #1;
        bus.rd_v_i = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
            if (bus.shape_v_o === 1'b1) begin
                bus.rd_v_i = 1'b0;
                return;
            end
            if (noise) begin
                bus.rd_v_i    = 1'($urandom_range(0, 1));
                bus.rd_addr_i = 5'($urandom_range(0, 31));
            end
        end
        bus.rd_v_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i       = 1'b1;
        bus.rd_v_i    = 1'b1;
        bus.rd_addr_i = {eT, 2'd0};
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (bus.rd_ready_o !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0", bus.rd_ready_o);
        end
        total++;
        if (bus.shape_v_o !== 1'b0) begin
            bad++; $display("FAIL reset_shape_v got=%b want=0", bus.shape_v_o);
        end
        total++;
        if (bus.shape_info_o !== shape_info_t'('0)) begin
            bad++; $display("FAIL reset_info got=%h want=0", bus.shape_info_o);
        end
        reset_i    = 1'b0;
        bus.rd_v_i = 1'b0;
        #1;
        total++;
        if (bus.rd_ready_o !== 1'b1) begin
            bad++; $display("FAIL idle_ready got=%b want=1", bus.rd_ready_o);
        end
    endtask

    task automatic test_directed();
        logic [4:0]  addrs [5];
        shape_info_t exps  [5];
        int lat;
        addrs[0] = {eI, 2'd0};   exps[0] = mk(16'h00F0, 0, 3, 1, 1, 1'b0);
        addrs[1] = {eI, 2'd1};   exps[1] = mk(16'h4444, 2, 2, 0, 3, 1'b0);
        addrs[2] = {eT, 2'd0};   exps[2] = mk(16'h0072, 0, 2, 0, 1, 1'b0);
        addrs[3] = {eO, 2'd2};   exps[3] = mk(16'h0066, 1, 2, 0, 1, 1'b0);
        addrs[4] = {eNon, 2'd3}; exps[4] = mk(16'h0000, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_request(addrs[i], 1'b0, lat);
            total++;
            if (lat !== 6) begin
                bad++; $display("FAIL directed%0d_latency got=%0d want=6", i, lat);
            end
            total++;
            if (bus.shape_info_o !== exps[i]) begin
                bad++; $display("FAIL directed%0d_info got=%h want=%h", i, bus.shape_info_o, exps[i]);
            end
        end
        // Result must hold while idling in DONE.
        repeat (4) @(negedge clk_i);
        total++;
        if (bus.shape_v_o !== 1'b1 || bus.rd_ready_o !== 1'b1) begin
            bad++; $display("FAIL done_sticky got=v%b/r%b want=v1/r1", bus.shape_v_o, bus.rd_ready_o);
        end
        total++;
        if (bus.shape_info_o !== exps[4]) begin
            bad++; $display("FAIL done_stable got=%h want=%h", bus.shape_info_o, exps[4]);
        end
    endtask

    task automatic test_cache();
        int lat;
        int want;
        shape_info_t e;
        e = mk(16'h0072, 0, 2, 0, 1, 1'b0);
        do_request({eT, 2'd0}, 1'b0, lat);
        total++;
        if (lat !== 6) begin
            bad++; $display("FAIL cache_first_latency got=%0d want=6", lat);
        end
`ifdef TILE_SHAPE_CACHE_EN
        want = 1;
`else
        want = 6;
`endif
        do_request({eT, 2'd0}, 1'b0, lat);
        total++;
        if (lat !== want) begin
            bad++; $display("FAIL cache_repeat_latency got=%0d want=%0d", lat, want);
        end
        total++;
        if (bus.shape_info_o !== e) begin
            bad++; $display("FAIL cache_repeat_info got=%h want=%h", bus.shape_info_o, e);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        bus.rd_addr_i = {eL, 2'd1};
        bus.rd_v_i    = 1'b1;
        @(posedge clk_i);
        #1;
        bus.rd_v_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i       = 1'b1;
        bus.rd_v_i    = 1'b1;
        bus.rd_addr_i = {eS, 2'd2};
        @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (bus.shape_v_o !== 1'b0 || bus.shape_info_o !== shape_info_t'('0)) begin
            bad++; $display("FAIL midreset_clear got=v%b/info%h want=v0/info0", bus.shape_v_o, bus.shape_info_o);
        end
        total++;
        if (bus.rd_ready_o !== 1'b0) begin
            bad++; $display("FAIL midreset_ready got=%b want=0", bus.rd_ready_o);
        end
        @(negedge clk_i);
        reset_i    = 1'b0;
        bus.rd_v_i = 1'b0;
        #1;
        total++;
        if (bus.rd_ready_o !== 1'b1) begin
            bad++; $display("FAIL midreset_idle got=%b want=1", bus.rd_ready_o);
        end
        repeat (10) @(negedge clk_i);
        total++;
        if (bus.shape_v_o !== 1'b0) begin
            bad++; $display("FAIL midreset_no_accept got=%b want=0", bus.shape_v_o);
        end
    endtask

    task automatic test_random();
        logic [4:0] a;
        logic [4:0] prev;
        bit have_prev;
        int lat;
        int want;
        shape_info_t e;
        have_prev = 1'b0;
        prev      = '0;
        for (int n = 0; n < 40; n++) begin
            if (n == 0) a = {eL, 2'd1};
            else if (have_prev && $urandom_range(0, 3) == 0) a = prev;
            else a = 5'($urandom_range(0, 31));
            e = model(a);
`ifdef TILE_SHAPE_CACHE_EN
            want = (have_prev && a == prev) ? 1 : 6;
`else
            want = 6;
`endif
            do_request(a, 1'b1, lat);
            total++;
            if (lat !== want) begin
                bad++; $display("FAIL rand%0d_latency addr=%h got=%0d want=%0d", n, a, lat, want);
            end
            total++;
            if (bus.shape_info_o !== e) begin
                bad++; $display("FAIL rand%0d_info addr=%h got=%h want=%h", n, a, bus.shape_info_o, e);
            end
            prev      = a;
            have_prev = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_v_i    = 1'b0;
        bus.rd_addr_i = '0;
        reset_i       = 1'b1;
        test_reset();
        test_directed();
        test_cache();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
